// File: rtl/ez90_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ez90_pkg                                                     |
// | Description : Shared eZ90 types: renamed uop, physical register id and     |
// |               the retirement stage state encoding.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ez90_pkg;

    localparam int c_PREG_W = 7;

    typedef logic [c_PREG_W-1:0] ez90_preg_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rd_valid;
        logic [4:0]  arch_rd;
        ez90_preg_t  pd_new;
        ez90_preg_t  pd_old;
    } ez90_uop_rn_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_TRAP_WAIT = 2'd2
    } ez90_commit_state_e;

endpackage
`default_nettype wire

// File: rtl/ez90_commit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ez90_commit_if                                               |
// | Description : ROB-head, retirement and trap signals of the commit stage.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ez90_commit_if #(
    parameter int IDX_W = 6
);
    import ez90_pkg::*;

    logic               head_valid;
    logic               head_done;
    ez90_uop_rn_t       head_uop;
    logic [IDX_W-1:0]   head_idx;
    logic               head_has_trap;
    logic [31:0]        head_trap_cause;
    logic               head_pop;
    logic               commit_ready;
    logic               commit_valid;
    logic [4:0]         commit_arch_rd;
    ez90_preg_t         commit_preg;
    logic               commit_rd_valid;
    logic               free_valid;
    ez90_preg_t         commit_free_preg;
    logic [IDX_W-1:0]   commit_rob_idx;
    logic               flush;
    logic               trap_valid;
    logic [31:0]        trap_cause;
    logic [31:0]        trap_pc;
    logic               trap_ready;

    // Commit stage side
    modport slave (
        input  head_valid, head_done, head_uop, head_idx, head_has_trap,
               head_trap_cause, commit_ready, trap_ready,
        output head_pop, commit_valid, commit_arch_rd, commit_preg,
               commit_rd_valid, free_valid, commit_free_preg, commit_rob_idx,
               flush, trap_valid, trap_cause, trap_pc
    );

    // ROB / consumers / trap handler side
    modport master (
        output head_valid, head_done, head_uop, head_idx, head_has_trap,
               head_trap_cause, commit_ready, trap_ready,
        input  head_pop, commit_valid, commit_arch_rd, commit_preg,
               commit_rd_valid, free_valid, commit_free_preg, commit_rob_idx,
               flush, trap_valid, trap_cause, trap_pc
    );

endinterface
`default_nettype wire

// File: rtl/ez90_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ez90_commit                                                  |
// | Description : In-order retirement of the ROB head; trapping heads raise a  |
// |               flush pulse and a held trap request. EZ90_COMMIT_PERF_EN     |
// |               adds retire/trap counters.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ez90_commit
    import ez90_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    ez90_commit_if.slave       cif
`ifdef EZ90_COMMIT_PERF_EN
    ,
    output logic [63:0]        retire_count,
    output logic [31:0]        trap_count
`endif
);

    ez90_commit_state_e r_state;
    ez90_commit_state_e w_state_next;
    logic               w_retire_ok;
    logic               w_trap_detect;

    logic               r_commit_valid;
    logic [4:0]         r_commit_arch_rd;
    ez90_preg_t         r_commit_preg;
    logic               r_commit_rd_valid;
    logic               r_free_valid;
    ez90_preg_t         r_commit_free_preg;
    logic [IDX_W-1:0]   r_commit_rob_idx;
    logic               r_flush;
    logic               r_trap_valid;
    logic [31:0]        r_trap_cause;
    logic [31:0]        r_trap_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A trapping head is acted on regardless of commit_ready: it is never retired.
    always_comb begin
        w_state_next  = r_state;
        w_retire_ok   = 1'b0;
        w_trap_detect = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_retire_ok   = cif.head_valid && cif.head_done &&
                                !cif.head_has_trap && cif.commit_ready;
                w_trap_detect = cif.head_valid && cif.head_done && cif.head_has_trap;
                if (w_trap_detect) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_next = ST_TRAP_WAIT;
            end
            ST_TRAP_WAIT: begin
                if (cif.trap_ready) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_valid     <= 1'b0;
            r_commit_arch_rd   <= '0;
            r_commit_preg      <= '0;
            r_commit_rd_valid  <= 1'b0;
            r_free_valid       <= 1'b0;
            r_commit_free_preg <= '0;
            r_commit_rob_idx   <= '0;
            r_flush            <= 1'b0;
            r_trap_valid       <= 1'b0;
            r_trap_cause       <= '0;
            r_trap_pc          <= '0;
        end else begin
            r_commit_valid <= w_retire_ok;
            // Physical register 0 is never handed back to the free list.
            r_free_valid   <= w_retire_ok && cif.head_uop.rd_valid &&
                              (cif.head_uop.pd_old != '0);
            r_flush        <= w_trap_detect;
            r_trap_valid   <= (w_state_next == ST_TRAP_WAIT);
            if (w_retire_ok) begin
                r_commit_arch_rd   <= cif.head_uop.arch_rd;
                r_commit_preg      <= cif.head_uop.pd_new;
                r_commit_rd_valid  <= cif.head_uop.rd_valid;
                r_commit_free_preg <= cif.head_uop.pd_old;
                r_commit_rob_idx   <= cif.head_idx;
            end
            if (w_trap_detect) begin
                r_trap_cause <= cif.head_trap_cause;
                r_trap_pc    <= cif.head_uop.pc;
            end
        end
    end

    assign cif.head_pop         = w_retire_ok;
    assign cif.commit_valid     = r_commit_valid;
    assign cif.commit_arch_rd   = r_commit_arch_rd;
    assign cif.commit_preg      = r_commit_preg;
    assign cif.commit_rd_valid  = r_commit_rd_valid;
    assign cif.free_valid       = r_free_valid;
    assign cif.commit_free_preg = r_commit_free_preg;
    assign cif.commit_rob_idx   = r_commit_rob_idx;
    assign cif.flush            = r_flush;
    assign cif.trap_valid       = r_trap_valid;
    assign cif.trap_cause       = r_trap_cause;
    assign cif.trap_pc          = r_trap_pc;

`ifdef EZ90_COMMIT_PERF_EN
    logic [63:0] r_retire_count;
    logic [31:0] r_trap_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_count <= '0;
            r_trap_count   <= '0;
        end else begin
            if (w_retire_ok) begin
                r_retire_count <= r_retire_count + 64'd1;
            end
            if (w_trap_detect) begin
                r_trap_count <= r_trap_count + 32'd1;
            end
        end
    end

    assign retire_count = r_retire_count;
    assign trap_count   = r_trap_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ez90_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ez90_commit                                               |
// | Description : Scoreboard bench for ez90_commit: directed and random heads. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ez90_commit;
    import ez90_pkg::*;

    typedef struct {
        ez90_uop_rn_t uop;
        logic [5:0]   idx;
        int           due;
    } exp_t;

    logic clk;
    logic rst;
    ez90_commit_if #(.IDX_W(6)) cif ();

`ifdef EZ90_COMMIT_PERF_EN
    logic [63:0] retire_count;
    logic [31:0] trap_count;
`endif

    ez90_commit #(.IDX_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .cif (cif)
`ifdef EZ90_COMMIT_PERF_EN
        ,
        .retire_count (retire_count),
        .trap_count   (trap_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc      = 0;
    bit     mon_en   = 1'b0;
    exp_t   sb[$];

    // Reference model: trap episode tracked by its detection cycle
    bit          m_in_trap  = 1'b0;
    int          m_trap_t   = 0;
    logic [31:0] m_cause    = '0;
    logic [31:0] m_pc       = '0;
    longint      m_retires  = 0;
    int          m_traps    = 0;
    bit          exp_pop    = 1'b0;
    bit          exp_flush  = 1'b0;
    bit          exp_tvalid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic drive_cycle(input bit hv, input bit hd, input bit ht, input bit cr,
                               input bit tr, input ez90_uop_rn_t u, input logic [5:0] idx,
                               input logic [31:0] cause);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        cif.head_valid      = hv;
        cif.head_done       = hd;
        cif.head_has_trap   = ht;
        cif.commit_ready    = cr;
        cif.trap_ready      = tr;
        cif.head_uop        = u;
        cif.head_idx        = idx;
        cif.head_trap_cause = cause;

        exp_flush  = m_in_trap && (cyc == m_trap_t + 1);
        exp_tvalid = m_in_trap && (cyc >= m_trap_t + 2);
        exp_pop    = !m_in_trap && hv && hd && !ht && cr;
        if (exp_pop) begin
            e.uop = u;
            e.idx = idx;
            e.due = cyc + 1;
            sb.push_back(e);
            m_retires++;
        end
        if (!m_in_trap && hv && hd && ht) begin
            m_in_trap = 1'b1;
            m_trap_t  = cyc;
            m_cause   = cause;
            m_pc      = u.pc;
            m_traps++;
        end else if (exp_tvalid && tr) begin
            m_in_trap = 1'b0;
        end
    endtask

    function automatic ez90_uop_rn_t mk_uop(input logic [31:0] pc, input bit rdv,
                                            input logic [4:0] rd, input int pn, input int po);
        ez90_uop_rn_t u;
        u.pc       = pc;
        u.rd_valid = rdv;
        u.arch_rd  = rd;
        u.pd_new   = ez90_preg_t'(pn);
        u.pd_old   = ez90_preg_t'(po);
        return u;
    endfunction

    function automatic ez90_uop_rn_t rand_uop();
        return mk_uop($urandom, $urandom_range(0, 3) != 0, 5'($urandom),
                      $urandom_range(1, 127),
                      ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 1, 0, '0, '0, '0);
    endtask

    // Monitor: compares DUT outputs against the model and pops the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            bit   exp_free;
            check("head_pop", cif.head_pop, exp_pop);
            check("flush", cif.flush, exp_flush);
            check("trap_valid", cif.trap_valid, exp_tvalid);
            if (exp_tvalid) begin
                check("trap_cause", cif.trap_cause, m_cause);
                check("trap_pc", cif.trap_pc, m_pc);
            end
            if (cif.commit_valid && cif.flush) flag("commit_valid_with_flush");
            if (cif.commit_valid) begin
                if (sb.size() == 0) begin
                    flag("commit_spurious");
                end else begin
                    e = sb.pop_front();
                    exp_free = e.uop.rd_valid && (e.uop.pd_old != 0);
                    check("commit_latency", cyc, e.due);
                    check("commit_arch_rd", cif.commit_arch_rd, e.uop.arch_rd);
                    check("commit_preg", cif.commit_preg, e.uop.pd_new);
                    check("commit_free_preg", cif.commit_free_preg, e.uop.pd_old);
                    check("commit_rd_valid", cif.commit_rd_valid, e.uop.rd_valid);
                    check("commit_rob_idx", cif.commit_rob_idx, e.idx);
                    check("free_valid", cif.free_valid, exp_free);
                end
            end else begin
                check("free_valid_idle", cif.free_valid, 1'b0);
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    flag("commit_missing");
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        cif.head_valid = 0; cif.head_done = 0; cif.head_has_trap = 0;
        cif.commit_ready = 0; cif.trap_ready = 0; cif.head_uop = '0;
        cif.head_idx = '0; cif.head_trap_cause = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_commit_valid", cif.commit_valid, 1'b0);
        check("rst_free_valid", cif.free_valid, 1'b0);
        check("rst_flush", cif.flush, 1'b0);
        check("rst_trap_valid", cif.trap_valid, 1'b0);
        check("rst_commit_preg", cif.commit_preg, '0);
        check("rst_trap_cause", cif.trap_cause, '0);
`ifdef EZ90_COMMIT_PERF_EN
        check("rst_retire_count", retire_count, '0);
`endif
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic retire: arch_rd 3, pd_new 40, pd_old 12
        drive_cycle(1, 1, 0, 1, 0, mk_uop(32'h100, 1, 5'd3, 40, 12), 6'd1, '0);
        idle(1);
        // Four back-to-back
        for (int i = 0; i < 4; i++)
            drive_cycle(1, 1, 0, 1, 0, mk_uop(32'h200 + 4 * i, 1, 5'(i + 1), 50 + i, 20 + i), 6'(2 + i), '0);
        // Consumers stalled for three cycles
        for (int i = 0; i < 3; i++)
            drive_cycle(1, 1, 0, 0, 0, mk_uop(32'h300, 1, 5'd7, 60, 30), 6'd6, '0);
        drive_cycle(1, 1, 0, 1, 0, mk_uop(32'h300, 1, 5'd7, 60, 30), 6'd6, '0);
        // No-free cases: rd_valid=0, pd_old=0
        drive_cycle(1, 1, 0, 1, 0, mk_uop(32'h304, 0, 5'd8, 61, 31), 6'd7, '0);
        drive_cycle(1, 1, 0, 1, 0, mk_uop(32'h308, 1, 5'd9, 62, 0), 6'd8, '0);
        // Trap at T, handshake at T+5
        drive_cycle(1, 1, 1, 1, 0, mk_uop(32'h1000, 1, 5'd1, 70, 33), 6'd9, 32'h2);
        for (int i = 0; i < 4; i++)
            drive_cycle(1, 1, 1, 1, 0, mk_uop(32'h1000, 1, 5'd1, 70, 33), 6'd9, 32'h2);
        drive_cycle(1, 1, 1, 1, 1, mk_uop(32'h1000, 1, 5'd1, 70, 33), 6'd9, 32'h2);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                        $urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0,
                        $urandom_range(0, 2) == 0, rand_uop(), 6'($urandom), $urandom);
        drive_cycle(0, 0, 0, 1, 1, '0, '0, '0);
        while (m_in_trap) drive_cycle(0, 0, 0, 1, 1, '0, '0, '0);
        idle(2);
        check("scoreboard_drained", sb.size(), 0);
`ifdef EZ90_COMMIT_PERF_EN
        check("retire_count", retire_count, m_retires);
        check("trap_count", trap_count, m_traps);
`endif

        // Reset asserted while waiting for the trap handshake
        drive_cycle(1, 1, 1, 1, 0, mk_uop(32'h2000, 1, 5'd2, 80, 40), 6'd10, 32'h5);
        idle(2);
        #2;
        mon_en = 1'b0;
        check("pre_rst_trap_valid", cif.trap_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("midtrap_rst_trap_valid", cif.trap_valid, 1'b0);
        check("midtrap_rst_flush", cif.flush, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_in_trap = 1'b0;
        m_retires = 0;
        m_traps   = 0;
        sb.delete();
        exp_pop = 0; exp_flush = 0; exp_tvalid = 0;
        mon_en  = 1'b1;
        idle(3);
`ifdef EZ90_COMMIT_PERF_EN
        check("post_rst_retire_count", retire_count, '0);
`endif
        for (int i = 0; i < 3; i++)
            drive_cycle(1, 1, 0, 1, 0, rand_uop(), 6'(i), '0);
        idle(2);
`ifdef EZ90_COMMIT_PERF_EN
        check("post_rst_retire_count_3", retire_count, 64'd3);
`endif
        check("final_scoreboard_drained", sb.size(), 0);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ez90_commit.md
# ez90_commit

In-order retirement stage for the eZ90 P7 core, directly downstream of the reorder buffer. It inspects the ROB head each cycle and retires at most one completed, trap-free uop by pulsing the ROB pop. Retirement publishes the architectural register mapping and frees the stale physical register. A trapping head uop instead triggers a one-cycle pipeline flush and a held trap request to the front-end/CSR logic.

## Interface
Parameters:
- IDX_W, 6, ROB index width; must match the ROB's alloc/head index width.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- head_valid  in  1  ROB non-empty.
- head_done  in  1  head uop has written back.
- head_uop  in  ez90_uop_rn_t  renamed uop at ROB head.
- head_idx  in  IDX_W  ROB slot of head.
- head_has_trap  in  1  head uop raised a trap.
- head_trap_cause  in  32  trap cause of head.
- head_pop  out  1  combinational; retire head this cycle.
- commit_ready  in  1  downstream retirement consumers (RAT/free list/store buffer) can accept.
- commit_valid  out  1  registered retire strobe.
- commit_arch_rd  out  5  architectural destination.
- commit_preg  out  ez90_preg_t  new physical mapping.
- commit_rd_valid  out  1  uop writes a register.
- free_valid  out  1  release commit_free_preg to free list.
- commit_free_preg  out  ez90_preg_t  previous mapping of arch_rd.
- commit_rob_idx  out  IDX_W  slot retired.
- flush  out  1  registered single-cycle flush pulse to ROB, rename, issue.
- trap_valid  out  1  trap request, held until accepted.
- trap_cause  out  32  latched cause.
- trap_pc  out  32  latched PC of trapping uop.
- trap_ready  in  1  trap handler accepts redirect.

## Operation
- States: RUN, FLUSH, TRAP_WAIT. Reset state RUN.
- retire_ok = RUN && head_valid && head_done && !head_has_trap && commit_ready.
- head_pop = retire_ok (combinational).
- On retire_ok, next cycle: commit_valid=1; commit_arch_rd/commit_preg/commit_free_preg/commit_rd_valid/commit_rob_idx from head_uop/head_idx; free_valid = head_uop.rd_valid && (pd_old != 0).
- RUN -> FLUSH when head_valid && head_done && head_has_trap (commit_ready ignored). Latch cause and head_uop.pc. No pop; trapping uop is not retired, frees nothing.
- FLUSH: flush=1 exactly this cycle, head_pop=0; -> TRAP_WAIT.
- TRAP_WAIT: trap_valid=1, cause/pc stable; head_pop=0. On trap_ready -> RUN next cycle.
- Incomplete head (head_done=0) or empty ROB: stall in RUN, no outputs.
- commit_ready=0 with retirable head: stall, head not popped, commit_valid=0 next cycle.

## Timing
- Reset (async, immediate): state RUN; commit_valid, free_valid, flush, trap_valid = 0; all data outputs 0; retire counter 0.
- Throughput one uop/cycle; retire latency head_done -> commit_valid = 1 cycle.
- Trap: detection cycle T, flush at T+1, trap_valid from T+2 until handshake cycle inclusive; first possible pop at handshake+1.
- commit_valid and flush are never high in the same cycle.
- rst asserted mid-trap: returns to RUN, trap_valid drops immediately, no flush pulse.

## Configuration
- EZ90_COMMIT_PERF_EN: when defined, adds output retire_count (64 bits) counting retire_ok cycles, wraps at 2^64, and output trap_count (32 bits) counting RUN->FLUSH transitions; both reset to 0 and are unaffected by flush. When undefined, neither the ports nor the counters exist.

## Structure
- ez90_pkg holds ez90_uop_rn_t (fields pc, rd_valid, arch_rd, pd_new, pd_old), ez90_preg_t, and the state enum ez90_commit_state_e.
- Single module. No sub-module. Counters stay inline under the macro.

## Test plan
- Head valid+done, no trap, commit_ready=1, arch_rd=3, pd_new=40, pd_old=12 -> head_pop same cycle; next cycle commit_valid=1, free_valid=1, commit_preg=40, commit_free_preg=12.
- Four back-to-back done uops -> four consecutive head_pop cycles and four consecutive commit_valid cycles.
- Head done with commit_ready=0 for 3 cycles -> no pop and no commit_valid; pop on the cycle ready rises.
- Head trap cause 0x2, pc 0x1000 at cycle T -> no pop; flush=1 at T+1 only; trap_valid with cause 0x2/pc 0x1000 from T+2; trap_ready at T+5 -> trap_valid=0 and state RUN at T+6.
- rd_valid=0 or pd_old=0 uop -> commit_valid=1, free_valid=0.
- rst pulsed during TRAP_WAIT -> trap_valid=0 immediately, no flush; with EZ90_COMMIT_PERF_EN, retire_count=0 after reset, and it increments by one per commit.
